// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type, line levels and bit-timing helper
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } uart_tx_state_t;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

   // Both periods are truncated to whole nanoseconds first so that the
   // transmitter and receiver derive the identical cycle count.
   function automatic int uart_cycles_per_bit(input int clk_hz, input int bit_rate);
      return (1_000_000_000 / bit_rate) / (1_000_000_000 / clk_hz);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit-period counter, cleared while not running
module uart_bit_timer #(
   parameter int CYCLES_PER_BIT = 86
) (
   input  logic clk,
   input  logic resetn,
   input  logic run,
   output logic bit_done
);

   localparam int CW = $clog2(CYCLES_PER_BIT) + 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(CYCLES_PER_BIT - 1);

   logic [CW-1:0] count_q, count_d;

   assign bit_done = run && (count_q == LAST_COUNT);

   // Count 0..CYCLES_PER_BIT-1 while running, wrap on bit_done, hold at 0 when stopped.
   always_comb begin
      count_d = count_q;
      if (!run || bit_done) begin
         count_d = '0;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter; optional parity bit under UART_TX_PARITY_EN
module uart_tx
   import uart_pkg::*;
#(
   parameter int BIT_RATE     = 576000,
   parameter int CLK_HZ       = 50_000_000,
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    uart_tx_valid,
   input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
   output logic                    uart_tx_ready,
   output logic                    uart_tx_busy,
   output logic                    uart_txd
);

   localparam int         CYCLES_PER_BIT = uart_cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam logic [3:0] LAST_DATA_IDX  = 4'(PAYLOAD_BITS - 1);
   localparam logic [3:0] LAST_STOP_IDX  = 4'(STOP_BITS - 1);

   uart_tx_state_t          state_q, state_d;
   logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
   logic [3:0]              idx_q, idx_d;
   logic                    txd_q, txd_d;
   logic                    accept;
   logic                    bit_done;
   logic                    timer_run;
`ifdef UART_TX_PARITY_EN
   logic                    parity_q, parity_d;
`endif

   assign uart_tx_ready = (state_q == TX_IDLE);
   assign uart_tx_busy  = ~uart_tx_ready;
   assign uart_txd      = txd_q;
   assign accept        = uart_tx_valid && uart_tx_ready;
   assign timer_run     = (state_q != TX_IDLE);

   uart_bit_timer #(
      .CYCLES_PER_BIT(CYCLES_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .resetn  (resetn),
      .run     (timer_run),
      .bit_done(bit_done)
   );

   // Frame sequencing; the line level is derived from the current state so
   // it appears one cycle after the state it belongs to.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      txd_d   = UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         TX_IDLE: begin
            if (accept) begin
               state_d = TX_START;
               shift_d = uart_tx_data;
`ifdef UART_TX_PARITY_EN
               parity_d = ^uart_tx_data;
`endif
            end
         end
         TX_START: begin
            txd_d = UART_START_LEVEL;
            if (bit_done) begin
               state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            txd_d = shift_q[0];
            if (bit_done) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 4'd1;
               if (idx_q == LAST_DATA_IDX) begin
`ifdef UART_TX_PARITY_EN
                  state_d = TX_PARITY;
`else
                  state_d = TX_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         TX_PARITY: begin
            txd_d = parity_q;
            if (bit_done) begin
               state_d = TX_STOP;
            end
         end
`endif
         TX_STOP: begin
            if (bit_done) begin
               idx_d = idx_q + 4'd1;
               if (idx_q == LAST_STOP_IDX) begin
                  state_d = TX_IDLE;
               end
            end
         end
         default: begin
            state_d = TX_IDLE;
         end
      endcase
      if (state_d != state_q) begin
         idx_d = '0;
      end
   end

   // State, shift register, index and registered line output.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= TX_IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         txd_q   <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises parallel payload words onto the `uart_txd` line: start bit, data LSB first, optional parity bit, then stop bits. It sits between a byte-stream producer (hash result dump, debug console) and the board TX pin. Its framing and bit timing match the existing `uart_rx`, so two instances loop back cleanly.

## Interface
Parameters:
- `BIT_RATE`, 576000: line bit rate in bits/s.
- `CLK_HZ`, 50_000_000: `clk` frequency in Hz.
- `PAYLOAD_BITS`, 8: data bits per frame, range 5..8.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.

Ports:
- Reset is `resetn`, synchronous, active-low. Clock is `clk`.
- `clk`  in  1  system clock.
- `resetn`  in  1  synchronous active-low reset.
- `uart_tx_valid`  in  1  producer has a word on `uart_tx_data`.
- `uart_tx_data`  in  PAYLOAD_BITS  word to send.
- `uart_tx_ready`  out  1  block can accept a word this cycle.
- `uart_tx_busy`  out  1  a frame is on the line; equals `!uart_tx_ready`.
- `uart_txd`  out  1  serial line, idle high.

## Operation
- `CYCLES_PER_BIT = (1_000_000_000/BIT_RATE) / (1_000_000_000/CLK_HZ)`, using integer division at each step. With the defaults this gives 1736/20 = 86.
- Every line bit lasts exactly `CYCLES_PER_BIT` cycles.
- Cycle counter width is `$clog2(CYCLES_PER_BIT)+1`. It counts 0..CYCLES_PER_BIT-1. `bit_done` is high when the count equals CYCLES_PER_BIT-1, and the counter then wraps to 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA on `bit_done`.
  - DATA -> PARITY (or STOP) on `bit_done` with bit index = PAYLOAD_BITS-1.
  - PARITY -> STOP on `bit_done`.
  - STOP -> IDLE on `bit_done` with stop index = STOP_BITS-1.
- Accept: `uart_tx_valid && uart_tx_ready`.
  - On accept, `uart_tx_data` is latched into a shift register.
  - The producer may change `uart_tx_data` on the next cycle.
- `uart_tx_ready` = (state == IDLE). No word is accepted in any other state. `valid` held during a frame is ignored until IDLE.
- `uart_txd` is registered:
  - START drives 0.
  - DATA drives shift-register bit 0; the register shifts right on each DATA `bit_done`.
  - PARITY drives the parity bit.
  - STOP and IDLE drive 1.
- Bit and stop index counter is 4 bits, reset to 0 on every state change.

## Timing
- Reset values: `uart_txd`=1, state IDLE, `uart_tx_ready`=1 on the first cycle after the reset edge, `uart_tx_busy`=0, counters 0, shift register 0.
- Latency: accept at edge N gives `uart_txd`=0 from edge N+1.
- Frame length is `(1 + PAYLOAD_BITS + P + STOP_BITS) * CYCLES_PER_BIT` cycles, where P = 1 with parity, else 0.
- Back-to-back: STOP -> IDLE happens at the last stop-bit edge. A word accepted in that first IDLE cycle starts its start bit one cycle later. The inter-frame gap is therefore exactly 1 extra idle cycle; there is no longer idle period.
- Reset mid-frame: the frame is abandoned. `uart_txd`=1 from the next edge and the state returns to IDLE. No partial-frame completion.
- `valid` deasserted in IDLE: the line stays 1 indefinitely and the counters hold at 0.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined:
  - The PARITY state is compiled in.
  - The parity bit is the even parity of the latched word (XOR of all data bits), sent after the last data bit.
  - Frame length includes P=1.
- Undefined:
  - The PARITY state and its logic are absent.
  - DATA goes directly to STOP.
- The matching receiver must be built with the same setting.

## Structure
- Package `uart_pkg`:
  - state enum `uart_tx_state_t`;
  - function `uart_cycles_per_bit(CLK_HZ, BIT_RATE)`;
  - idle-level and start-level constants.
- Sub-module `uart_bit_timer`: parameter `CYCLES_PER_BIT`, inputs `clk`, `resetn`, `run`, output `bit_done`; the counter clears when `run` is low. Both the transmitter and future receiver revisions use it.

## Test plan
- Reset then idle: hold `resetn`=0 for 3 cycles, then release with `valid`=0 for 1000 cycles -> `uart_txd`=1 and `ready`=1 throughout.
- Single byte: send 0xA5 at the defaults -> line reads 0, then 1,0,1,0,0,1,0,1, then 1. Each level is held 86 cycles; `ready` returns 860 cycles after accept.
- Back-to-back: keep `valid`=1 and send 0x00 then 0xFF -> second start bit begins 1 cycle after the first frame's stop bit ends. Loopback into `uart_rx` yields 0x00 then 0xFF with `uart_rx_valid` pulsed twice.
- Data stability: change `uart_tx_data` to 0x3C one cycle after accepting 0x81 -> line still carries 0x81.
- Reset mid-frame: assert `resetn`=0 during data bit 3 -> `uart_txd`=1 on the next edge, and `ready`=1 after release.
- With `UART_TX_PARITY_EN`: send 0x07 -> parity bit 1 follows data, frame is 946 cycles. Send 0x03 -> parity bit 0.
